// File: rtl/word32b_8b_c_pkg.sv
// Shared definitions for the word32b_8b_c word-to-byte unpacker.
//   - IN_W_DEF / OUT_W_DEF : default word and byte widths
//   - nbOf()               : bytes per word derivation
//   - LSB_FIRST            : byte order; set when W32B_8B_LSB_FIRST_EN is defined
//   - state_e              : IDLE/SHIFT encodings, shared with the packer's bench
package word32b_8b_c_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 8;

`ifdef W32B_8B_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int nbOf(input int inW, input int outW);
    return inW / outW;
  endfunction

endpackage

// File: rtl/word32b_8b_hold.sv
// Single-entry hold register for the word32b_8b_c unpacker.
// Ports:
//   clk_4f_c  in   byte-rate clock
//   reset     in   synchronous, active-low
//   load_i    in   capture data_i into the hold
//   drain_i   in   hold contents are taken by the shifter this edge
//   data_i    in   word to capture
//   data_o    out  held word
//   valid_o   out  hold occupied
//   ready_o   out  combinational: out of reset and hold empty
module word32b_8b_hold #(
  parameter int IN_W = 32
) (
  input  logic            clk_4f_c,
  input  logic            reset,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic [IN_W-1:0] data_i,
  output logic [IN_W-1:0] data_o,
  output logic            valid_o,
  output logic            ready_o
);

  logic [IN_W-1:0] data_q;
  logic            valid_q;

  // A load on the same edge as a drain refills the entry, so load wins.
  always_ff @(posedge clk_4f_c) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ready_o = reset & ~valid_q;

endmodule

// File: rtl/word32b_8b_c.sv
// word32b_8b_c: word-to-byte unpacker on the clk_4f_c domain.
// Accepts IN_W-bit words (valid/ready) and emits NB = IN_W/OUT_W bytes on
// consecutive cycles, MSB first by default, LSB first when the macro
// W32B_8B_LSB_FIRST_EN is defined. A one-word hold keeps a 1-word-per-NB
// stream gap-free.
// Ports:
//   clk_4f_c     in   byte-rate clock
//   reset        in   synchronous, active-low
//   valid_in     in   Data_in holds a word
//   Data_in      in   word to unpack
//   ready_out    out  combinational, reset & ~hold_valid
//   valid_out_c  out  registered byte valid
//   Data_out_c   out  registered byte
module word32b_8b_c
  import word32b_8b_c_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk_4f_c,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  Data_in,
  output logic             ready_out,
  output logic             valid_out_c,
  output logic [OUT_W-1:0] Data_out_c
);

  localparam int NB = nbOf(IN_W, OUT_W);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [IN_W-1:0]  shift_q;
  logic [OUT_W-1:0] dout_q;
  logic             vout_q;

  logic [IN_W-1:0]  holdData;
  logic             holdValid;
  logic             accept;
  logic             loadPoint;
  logic             holdLoad;
  logic             holdDrain;
  logic             haveSrc;
  logic [IN_W-1:0]  srcWord;

  function automatic logic [OUT_W-1:0] pickByte(input logic [IN_W-1:0] w,
                                                input logic [CW-1:0]   k);
    if (LSB_FIRST) return w[int'(k)*OUT_W +: OUT_W];
    else           return w[IN_W-1-int'(k)*OUT_W -: OUT_W];
  endfunction

  // Load point: the shifter is empty or emitting its last byte this cycle.
  // The hold has priority as a source; a word accepted at a load point with
  // an empty hold bypasses straight into the shifter.
  assign accept    = valid_in & ready_out;
  assign loadPoint = (state_q == ST_IDLE) || (cnt_q == CW'(NB - 1));
  assign holdDrain = loadPoint & holdValid;
  assign holdLoad  = accept & (~loadPoint | holdValid);
  assign haveSrc   = holdValid | accept;
  assign srcWord   = holdValid ? holdData : Data_in;
  assign cnt_d     = cnt_q + 1'b1;

  word32b_8b_hold #(
    .IN_W (IN_W)
  ) u_hold (
    .clk_4f_c (clk_4f_c),
    .reset    (reset),
    .load_i   (holdLoad),
    .drain_i  (holdDrain),
    .data_i   (Data_in),
    .data_o   (holdData),
    .valid_o  (holdValid),
    .ready_o  (ready_out)
  );

  always_ff @(posedge clk_4f_c) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
    end else if (loadPoint) begin
      if (haveSrc) begin
        state_q <= ST_SHIFT;
        shift_q <= srcWord;
        cnt_q   <= '0;
        dout_q  <= pickByte(srcWord, CW'(0));
        vout_q  <= 1'b1;
      end else begin
        state_q <= ST_IDLE;
        dout_q  <= '0;
        vout_q  <= 1'b0;
      end
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= pickByte(shift_q, cnt_d);
      vout_q <= 1'b1;
    end
  end

  assign valid_out_c = vout_q;
  assign Data_out_c  = dout_q;

endmodule
